// File: rtl/spi_xcvr_if.sv
// Byte-level link between the SPI transceiver and the register sequencer.
// The transceiver side is the master; the sequencer is the slave.
interface spi_xcvr_if;
  logic       cs_active_i;
  logic       rx_valid_i;
  logic [7:0] rx_data_i;
  logic       tx_load_o;
  logic [7:0] tx_data_o;

  modport master (
    output cs_active_i,
    output rx_valid_i,
    output rx_data_i,
    input  tx_load_o,
    input  tx_data_o
  );

  modport slave (
    input  cs_active_i,
    input  rx_valid_i,
    input  rx_data_i,
    output tx_load_o,
    output tx_data_o
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Command sequencer: parses each chip-select frame into a command byte plus data
// bytes, writes the register bank or feeds read-back bytes to the transceiver.
module spi_reg_ctrl #(
  parameter int unsigned NOF_DATA_WORDS   = 2,
  parameter int unsigned NOF_ADDRESS_BITS = 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  spi_xcvr_if.slave                     xcvr,
  output logic [8*NOF_DATA_WORDS-1:0]   words_o,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int unsigned AW = NOF_ADDRESS_BITS;
  localparam int unsigned NW = NOF_DATA_WORDS;

  typedef logic [AW-1:0] ptr_t;
  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  state_t     state_q, state_d;
  ptr_t       ptr_q, ptr_d;
  logic       inc_q, inc_d;
  logic       cs_q, cs_d;
  logic [7:0] words_q [NW];
  logic [7:0] words_d [NW];
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_load_q, tx_load_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  function automatic logic ptr_valid(ptr_t p);
    return 32'(p) < NW;
  endfunction

  // Invalid pointers stay put; the last valid word wraps to word 0.
  function automatic ptr_t ptr_next(ptr_t p, logic inc);
    if (!inc || !ptr_valid(p)) return p;
    if (32'(p) == NW - 1) return '0;
    return p + AW'(1);
  endfunction

  function automatic logic [7:0] word_at(ptr_t p);
    logic [7:0] w;
    w = 8'h00;
    for (int unsigned n = 0; n < NW; n++) begin
      if (32'(p) == n) w = words_q[n];
    end
    return w;
  endfunction

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      inc_q     <= 1'b0;
      // Held high so a chip select already asserted at reset release is not a frame start.
      cs_q      <= 1'b1;
      tx_data_q <= 8'h00;
      tx_load_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      for (int unsigned n = 0; n < NW; n++) words_q[n] <= 8'h00;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      inc_q     <= inc_d;
      cs_q      <= cs_d;
      tx_data_q <= tx_data_d;
      tx_load_q <= tx_load_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      for (int unsigned n = 0; n < NW; n++) words_q[n] <= words_d[n];
    end
  end

  always_comb begin
    ptr_t load_ptr;
    logic do_load;

    state_d   = state_q;
    ptr_d     = ptr_q;
    inc_d     = inc_q;
    cs_d      = xcvr.cs_active_i;
    words_d   = words_q;
    tx_data_d = tx_data_q;
    tx_load_d = 1'b0;
    err_d     = err_q;
    load_ptr  = ptr_q;
    do_load   = 1'b0;

    if (!xcvr.cs_active_i) begin
      // Frame end or abort wins over any byte arriving in the same cycle.
      state_d = IDLE;
      ptr_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!cs_q) begin
            state_d = CMD;
            err_d   = 1'b0;
          end
        end
        CMD: begin
          if (xcvr.rx_valid_i) begin
            load_ptr = xcvr.rx_data_i[AW-1:0];
            inc_d    = xcvr.rx_data_i[6];
            if (xcvr.rx_data_i[7]) begin
              state_d = READ;
              do_load = 1'b1;
              ptr_d   = ptr_next(load_ptr, xcvr.rx_data_i[6]);
            end else begin
              state_d = WRITE;
              ptr_d   = load_ptr;
            end
          end
        end
        WRITE: begin
          if (xcvr.rx_valid_i) begin
            if (ptr_valid(ptr_q)) begin
              for (int unsigned n = 0; n < NW; n++) begin
                if (32'(ptr_q) == n) words_d[n] = xcvr.rx_data_i;
              end
            end else begin
              err_d = 1'b1;
            end
            ptr_d = ptr_next(ptr_q, inc_q);
          end
        end
        READ: begin
          if (xcvr.rx_valid_i) begin
            do_load = 1'b1;
            ptr_d   = ptr_next(ptr_q, inc_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (do_load) begin
      tx_load_d = 1'b1;
      if (ptr_valid(load_ptr)) begin
        tx_data_d = word_at(load_ptr);
      end else begin
        tx_data_d = 8'h00;
        err_d     = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  for (genvar g = 0; g < NW; g++) begin : g_pack
    assign words_o[8*g +: 8] = words_q[g];
  end

  assign xcvr.tx_load_o = tx_load_q;
  assign xcvr.tx_data_o = tx_data_q;
  assign busy_o         = busy_q;
  assign err_o          = err_q;

endmodule
